// File: rtl/accel_pkg.sv
// Purpose : shared types and FP8/INT8 field constants for the activation stage.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: act_mode_t, state_t, lane width, FP8 E4M3 exponent field position,
//           leaky-ReLU shift, and the FP8 leaky helper.
package accel_pkg;

    localparam int LANE_W      = 8;
    localparam int EXP_MSB     = 6;
    localparam int EXP_LSB     = 3;
    localparam int EXP_W       = EXP_MSB - EXP_LSB + 1;
    localparam int LEAKY_SHIFT = 3;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_LEAKY = 2'b10
    } act_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Negative FP8 E4M3 times 1/8: dividing by 2^LEAKY_SHIFT is an exponent
    // subtract. Anything that would go subnormal or below is flushed to +0.
    function automatic logic [LANE_W-1:0] fp8_leaky(input logic [LANE_W-1:0] x);
        logic [EXP_W-1:0] exp_f;
        exp_f = x[EXP_MSB:EXP_LSB];
        if (exp_f > EXP_W'(LEAKY_SHIFT))
            return {1'b1, exp_f - EXP_W'(LEAKY_SHIFT), x[EXP_LSB-1:0]};
        else
            return '0;
    endfunction

endpackage

// File: rtl/activation_lane.sv
// Purpose : one-lane activation (pass / ReLU / leaky) for INT8 or FP8 E4M3.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports   : i_din lane value, i_float selects FP8 decode, i_mode activation,
//           o_dout activated lane value.
module lane_activate
    import accel_pkg::*;
(
    input  logic [LANE_W-1:0] i_din,
    input  logic              i_float,
    input  act_mode_t         i_mode,
    output logic [LANE_W-1:0] o_dout
);

    logic              w_neg;
    logic [LANE_W-1:0] w_int_leaky;
    logic [LANE_W-1:0] w_fp_leaky;

    // The sign bit sits at the MSB in both INT8 and FP8, so only negative
    // inputs are ever altered.
    assign w_neg       = i_din[LANE_W-1];
    assign w_int_leaky = LANE_W'($signed(i_din) >>> LEAKY_SHIFT);
    assign w_fp_leaky  = fp8_leaky(i_din);

    always_comb begin
        o_dout = i_din;
        if (w_neg) begin
            case (i_mode)
                ACT_RELU:  o_dout = '0;
                ACT_LEAKY: o_dout = i_float ? w_fp_leaky : w_int_leaky;
                default:   o_dout = i_din;
            endcase
        end
    end

endmodule

// File: rtl/activation_unit.sv
// Purpose : per-lane activation of bias-adder beats, buffered in a DEPTH-entry
//           FIFO, with a tile FSM counting rows and tracking overflow.
// Latency : beat accepted at edge k is on out_data/out_valid after edge k.
// Backpressure: input_ready only in ACTIVE with FIFO space; no pop bypass.
// Ports   : clk/rst (sync active-high); start, act_mode, float tile config;
//           bias_outputs/overflow/input_valid/input_ready input beat;
//           out_data/out_valid/out_ready output beat; tile_done,
//           overflow_sticky, row_count tile status.
module activation_unit
    import accel_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int DATA_W = 8,
    parameter int ROWS   = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 act_mode,
    input  logic                       float,
    input  logic [LANES*DATA_W-1:0]    bias_outputs,
    input  logic                       overflow,
    input  logic                       input_valid,
    output logic                       input_ready,
    output logic [LANES*DATA_W-1:0]    out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       tile_done,
    output logic                       overflow_sticky,
    output logic [$clog2(ROWS+1)-1:0]  row_count
);

    localparam int BEAT_W = LANES * DATA_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ROW_W  = $clog2(ROWS + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    act_mode_t          r_mode;
    logic               r_float;
    logic [ROW_W-1:0]   r_row_count;
    logic               r_ovf_sticky;

    logic [BEAT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [BEAT_W-1:0]  r_out_data;

    logic [BEAT_W-1:0]  w_act_dat;
    logic               w_in_rdy;
    logic               w_tile_done;
    logic               w_push;
    logic               w_pop;
    logic               w_last_beat;
    logic [PTR_W-1:0]   w_rd_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BEAT_W-1:0]  w_head_nxt;

    // ------------------------------------------------------------------
    // Lane datapath
    // ------------------------------------------------------------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_activate u_lane (
            .i_din   (bias_outputs[g*DATA_W +: DATA_W]),
            .i_float (r_float),
            .i_mode  (r_mode),
            .o_dout  (w_act_dat[g*DATA_W +: DATA_W])
        );
    end

    assign w_push      = input_valid & w_in_rdy;
    assign w_pop       = (r_count != '0) & out_ready;
    assign w_last_beat = w_push & (r_row_count == ROW_W'(ROWS - 1));

    // ------------------------------------------------------------------
    // Tile FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start)          w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_last_beat)    w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (r_count == '0)  w_state_nxt = ST_DONE;
            ST_DONE:                       w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_rdy    = (r_state == ST_ACTIVE) && (r_count < CNT_W'(DEPTH));
        w_tile_done = (r_state == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Tile configuration and status. Status holds after DONE until the
    // next honoured start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode       <= ACT_PASS;
            r_float      <= 1'b0;
            r_row_count  <= '0;
            r_ovf_sticky <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            case (act_mode)
                2'b01:   r_mode <= ACT_RELU;
                2'b10:   r_mode <= ACT_LEAKY;
                default: r_mode <= ACT_PASS;
            endcase
            r_float      <= float;
            r_row_count  <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (w_push) begin
            if (r_row_count < ROW_W'(ROWS))
                r_row_count <= r_row_count + ROW_W'(1);
            r_ovf_sticky <= r_ovf_sticky | overflow;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. out_data is a register that tracks the head entry and
    // only updates while the FIFO will be non-empty, so it holds the last
    // delivered beat when empty and is stable while stalled.
    // ------------------------------------------------------------------
    assign w_rd_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    // The next head is the beat being written this edge when the write slot
    // is exactly where the read pointer will land (FIFO empty after the pop).
    assign w_head_nxt = (w_push && (r_wr_ptr == w_rd_nxt)) ? w_act_dat : r_mem[w_rd_nxt];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_act_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            if (w_cnt_nxt != '0) r_out_data <= w_head_nxt;
        end
    end

    assign input_ready     = w_in_rdy;
    assign out_valid       = (r_count != '0);
    assign out_data        = r_out_data;
    assign tile_done       = w_tile_done;
    assign overflow_sticky = r_ovf_sticky;
    assign row_count       = r_row_count;

endmodule

// File: tb/tb_activation_unit.sv
module tb_activation_unit;

    localparam int LANES = 8;
    localparam int DATA_W = 8;
    localparam int ROWS = 8;
    localparam int DEPTH = 4;

    localparam int M_IDLE = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  act_mode;
    logic        float;
    logic [63:0] bias_outputs;
    logic        overflow;
    logic        input_valid;
    logic        input_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        tile_done;
    logic        overflow_sticky;
    logic [3:0]  row_count;

    always #5 clk = ~clk;

    activation_unit #(.LANES(LANES), .DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .act_mode        (act_mode),
        .float           (float),
        .bias_outputs    (bias_outputs),
        .overflow        (overflow),
        .input_valid     (input_valid),
        .input_ready     (input_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .tile_done       (tile_done),
        .overflow_sticky (overflow_sticky),
        .row_count       (row_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference activation from the arithmetic rules -------
    function automatic logic [7:0] act_ref(input logic [7:0] x, input logic [1:0] mode, input logic fl);
        int u;
        int v;
        int e;
        int m;
        u = int'(x);
        if (mode == 2'b00 || mode == 2'b11) return x;
        if (u < 128) return x;              // non-negative in both formats
        if (mode == 2'b01) return 8'h00;
        if (!fl) begin
            v = u - 256;                    // INT8 value, negative
            v = -((-v + 7) / 8);            // floor(v / 8)
            return 8'(v);
        end
        e = (u / 8) % 16;
        m = u % 8;
        if (e <= 3) return 8'h00;
        return 8'(128 + (e - 3) * 8 + m);
    endfunction

    function automatic logic [63:0] beat_ref(input logic [63:0] b, input logic [1:0] mode, input logic fl);
        logic [63:0] r;
        for (int l = 0; l < LANES; l++) r[l*8 +: 8] = act_ref(b[l*8 +: 8], mode, fl);
        return r;
    endfunction

    function automatic logic [63:0] pat(input int i);
        return 64'(i + 1) * 64'h9E37_79B9_7F4A_7C15;
    endfunction

    // ---------------- behavioural model ------------------------------------
    logic [63:0] mq[$];
    int          m_phase = M_IDLE;
    int          m_rows = 0;
    bit          m_sticky = 1'b0;
    logic [1:0]  m_mode = 2'b00;
    bit          m_fl = 1'b0;
    logic [63:0] m_last = '0;
    bit          chk_en = 1'b0;
    int          done_pulses = 0;

    always @(posedge clk) begin : model
        bit acc;
        bit pop;
        bit empty0;
        if (rst) begin
            mq.delete();
            m_phase  = M_IDLE;
            m_rows   = 0;
            m_sticky = 1'b0;
            m_last   = '0;
            m_mode   = 2'b00;
            m_fl     = 1'b0;
        end else begin
            empty0 = (mq.size() == 0);
            acc    = (m_phase == M_ACTIVE) && input_valid && (mq.size() < DEPTH);
            pop    = !empty0 && out_ready;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(beat_ref(bias_outputs, m_mode, m_fl));
                if (m_rows < ROWS) m_rows++;
                m_sticky = m_sticky | overflow;
            end
            case (m_phase)
                M_IDLE: if (start) begin
                    m_phase  = M_ACTIVE;
                    m_rows   = 0;
                    m_sticky = 1'b0;
                    m_mode   = act_mode;
                    m_fl     = float;
                end
                M_ACTIVE: if (acc && m_rows == ROWS) m_phase = M_DRAIN;
                M_DRAIN:  if (empty0) m_phase = M_DONE;
                default:  m_phase = M_IDLE;
            endcase
            if (mq.size() > 0) m_last = mq[0];
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("out_data", out_data, m_last);
            chk("input_ready", 64'(input_ready), 64'((m_phase == M_ACTIVE) && (mq.size() < DEPTH)));
            chk("tile_done", 64'(tile_done), 64'(m_phase == M_DONE));
            chk("overflow_sticky", 64'(overflow_sticky), 64'(m_sticky));
            chk("row_count", 64'(row_count), 64'(m_rows));
            if (tile_done === 1'b1) done_pulses++;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [1:0] mode, input logic fl);
        start = 1'b1;
        act_mode = mode;
        float = fl;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic ov);
        bit ok;
        ok = 1'b0;
        bias_outputs = d;
        overflow = ov;
        input_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            ok = input_ready;
            tick();
        end
        input_valid = 1'b0;
        overflow = 1'b0;
        chk("beat_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_done();
        int p0;
        p0 = done_pulses;
        for (int k = 0; k < 60 && done_pulses == p0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("tile_done_pulses", 64'(done_pulses - p0), 64'd1);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int p;
        rst = 1'b1;
        start = 1'b0;
        act_mode = 2'b00;
        float = 1'b0;
        bias_outputs = '0;
        overflow = 1'b0;
        input_valid = 1'b0;
        out_ready = 1'b1;

        // Reset values
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_input_ready", 64'(input_ready), 64'd0);
        chk("rst_tile_done", 64'(tile_done), 64'd0);
        chk("rst_sticky", 64'(overflow_sticky), 64'd0);
        chk("rst_row_count", 64'(row_count), 64'd0);
        rst = 1'b0;

        // INT8 ReLU
        start_tile(2'b01, 1'b0);
        send_beat(64'hC0_10_90_7F_01_00_FF_80, 1'b0);
        @(negedge clk);
        chk("int8_relu_valid", 64'(out_valid), 64'd1);
        chk("int8_relu_data", out_data, 64'h00_10_00_7F_01_00_00_00);
        for (int i = 1; i < ROWS; i++) send_beat(pat(i), 1'b0);
        wait_done();

        // INT8 leaky
        start_tile(2'b10, 1'b0);
        send_beat(64'h81_F0_7F_00_05_FF_80_F8, 1'b0);
        @(negedge clk);
        chk("int8_leaky_data", out_data, 64'hF0_FE_7F_00_05_FF_F0_FF);
        for (int i = 1; i < ROWS; i++) send_beat(pat(i + 10), 1'b0);
        wait_done();

        // FP8 leaky
        start_tile(2'b10, 1'b1);
        send_beat(64'h7F_A0_C5_FF_80_38_98_B8, 1'b0);
        @(negedge clk);
        chk("fp8_leaky_data", out_data, 64'h7F_88_AD_E7_00_38_00_A0);
        for (int i = 1; i < ROWS; i++) send_beat(pat(i + 20), 1'b0);
        wait_done();

        // FP8 ReLU
        start_tile(2'b01, 1'b1);
        send_beat(64'h81_01_7F_FF_00_80_38_B8, 1'b0);
        @(negedge clk);
        chk("fp8_relu_data", out_data, 64'h00_01_7F_00_00_00_38_00);
        for (int i = 1; i < ROWS; i++) send_beat(pat(i + 30), 1'b0);
        wait_done();

        // Stalled consumer, overflow on beat 3, ignored start, mode 11 = pass
        out_ready = 1'b0;
        start_tile(2'b11, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            send_beat(pat(i + 40), (i == 2));
            @(negedge clk);
            chk("sticky_progress", 64'(overflow_sticky), 64'(i >= 2));
        end
        @(negedge clk);
        chk("full_input_ready", 64'(input_ready), 64'd0);
        chk("full_row_count", 64'(row_count), 64'd4);
        chk("full_head", out_data, pat(40));
        start = 1'b1;
        act_mode = 2'b01;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("ignored_start_rows", 64'(row_count), 64'd4);
        out_ready = 1'b1;
        for (int i = DEPTH; i < ROWS; i++) send_beat(pat(i + 40), 1'b0);
        wait_done();
        chk("hold_sticky", 64'(overflow_sticky), 64'd1);
        chk("hold_rows", 64'(row_count), 64'd8);
        chk("hold_last_data", out_data, pat(47));

        // Reset while draining with two entries queued
        out_ready = 1'b0;
        start_tile(2'b00, 1'b0);
        @(negedge clk);
        chk("restart_sticky", 64'(overflow_sticky), 64'd0);
        chk("restart_rows", 64'(row_count), 64'd0);
        for (int i = 0; i < DEPTH; i++) send_beat(pat(i + 60), 1'b0);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        for (int i = DEPTH; i < ROWS; i++) send_beat(pat(i + 60), 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("drain_valid", 64'(out_valid), 64'd1);
        chk("drain_rows", 64'(row_count), 64'd8);
        p = done_pulses;
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_tile_done", 64'(tile_done), 64'd0);
        chk("midrst_rows", 64'(row_count), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("midrst_no_done", 64'(done_pulses - p), 64'd0);
        start_tile(2'b01, 1'b0);
        @(negedge clk);
        chk("idle_after_rst", 64'(input_ready), 64'd1);
        for (int i = 0; i < ROWS; i++) send_beat(pat(i + 80), 1'b0);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
